fetch_controller: RTL and testbench

Sequences the program counter and instruction-cache front end of the 16-bit RISC core. Every cycle it picks the next fetch address (sequential, branch, jump or hold), drives the PC's load enable and next-address inputs, and runs the miss/refill handshake with instruction memory. Redirects that arrive during a refill are buffered. It sits between the PC register, the instruction cache, and the decode/branch-resolution logic.

---
 rtl/fetch_ctrl_pkg.sv | 17 +
 rtl/pc_next_sel.sv | 49 ++++
 rtl/fetch_controller.sv | 122 ++++++++++++
 tb/tb_fetch_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch front end: state encoding,
// default address width and reset vector, and the size of the redirect mux.
package fetch_ctrl_pkg;

  localparam int          DEFAULT_ADDR_W       = 16;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

  // Redirect sources in priority order: branch, jump, buffered redirect.
  localparam int NUM_REDIRECT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MISS  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Priority selector for the next PC value. Redirect requests are ranked by
// index (0 wins); with no redirect the address is either held or incremented.
module pc_next_sel
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [NUM_REDIRECT-1:0]        redirect_req,
  input  logic [NUM_REDIRECT*ADDR_W-1:0] redirect_target,
  input  logic                           hold,
  input  logic [ADDR_W-1:0]              current_address,
  output logic [ADDR_W-1:0]              next_address,
  output logic                           pc_enable
);

  // claimed[i] is set when any source with index below i is requesting.
  logic [NUM_REDIRECT:0]   claimed;
  logic [NUM_REDIRECT-1:0] grant;
  logic [ADDR_W-1:0]       masked_target [NUM_REDIRECT];
  logic [ADDR_W-1:0]       seq_address;

  assign claimed[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REDIRECT; gi++) begin : g_prio
      assign grant[gi]         = redirect_req[gi] & ~claimed[gi];
      assign claimed[gi+1]     = claimed[gi] | redirect_req[gi];
      assign masked_target[gi] = grant[gi] ? redirect_target[gi*ADDR_W +: ADDR_W] : '0;
    end
  endgenerate

  // Sequential successor wraps modulo 2^ADDR_W by plain truncation.
  assign seq_address = current_address + ADDR_W'(1);

  // Grant is one-hot, so OR-ing the masked targets yields the winner.
  always_comb begin
    next_address = hold ? current_address : seq_address;
    pc_enable    = ~hold;
    if (claimed[NUM_REDIRECT]) begin
      next_address = '0;
      for (int i = 0; i < NUM_REDIRECT; i++) begin
        next_address = next_address | masked_target[i];
      end
      pc_enable = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: chooses the next fetch address each cycle, runs the
// icache miss/refill handshake and buffers redirects seen during a refill.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic              inp_clk,
  input  logic              inp_rst,
  input  logic              inp_cacheHit,
  input  logic              inp_fillDone,
  input  logic              inp_stall,
  input  logic              inp_branchTaken,
  input  logic [ADDR_W-1:0] inp_branchTarget,
  input  logic              inp_jump,
  input  logic [ADDR_W-1:0] inp_jumpTarget,
  output logic [ADDR_W-1:0] out_fetchAddress,
  output logic [ADDR_W-1:0] out_nextInstructionAddress,
  output logic              out_pcEnable,
  output logic              out_fillReq,
  output logic [ADDR_W-1:0] out_fillAddress,
  output logic              out_instValid,
  output logic [1:0]        out_state
);

  fetch_state_e      state_reg;
  logic [ADDR_W-1:0] fetch_address_reg;
  logic [ADDR_W-1:0] fill_address_reg;
  logic [ADDR_W-1:0] pend_target_reg;
  logic              fill_req_reg;
  logic              pend_valid_reg;

  logic                           in_fetch;
  logic                           in_miss;
  logic                           fill_exit;
  logic                           redirect_window;
  logic                           any_redirect;
  logic                           miss_detect;
  logic                           hold;
  logic [NUM_REDIRECT-1:0]        redirect_req;
  logic [NUM_REDIRECT*ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0]              next_address;
  logic                           pc_enable;

  assign in_fetch  = (state_reg == ST_FETCH);
  assign in_miss   = (state_reg == ST_MISS);
  assign fill_exit = in_miss & inp_fillDone;

  // Redirects steer the PC only in FETCH or on the cycle a refill completes;
  // otherwise during MISS they are merely recorded.
  assign redirect_window = in_fetch | fill_exit;
  assign any_redirect    = inp_branchTaken | inp_jump;

  assign redirect_req = {fill_exit & pend_valid_reg,
                         redirect_window & inp_jump,
                         redirect_window & inp_branchTaken};
  assign redirect_target = {pend_target_reg, inp_jumpTarget, inp_branchTarget};

  assign hold        = ~in_fetch | ~inp_cacheHit | inp_stall;
  assign miss_detect = in_fetch & ~any_redirect & ~inp_cacheHit;

  pc_next_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_sel (
    .redirect_req    (redirect_req),
    .redirect_target (redirect_target),
    .hold            (hold),
    .current_address (fetch_address_reg),
    .next_address    (next_address),
    .pc_enable       (pc_enable)
  );

  // FSM plus fetch/fill/pending registers, all advanced on one edge.
  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      state_reg         <= ST_IDLE;
      fetch_address_reg <= RESET_VECTOR;
      fill_req_reg      <= 1'b0;
      fill_address_reg  <= '0;
      pend_valid_reg    <= 1'b0;
      pend_target_reg   <= '0;
    end else begin
      fetch_address_reg <= next_address;
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_FETCH;
        end
        ST_FETCH: begin
          if (miss_detect) begin
            state_reg        <= ST_MISS;
            fill_req_reg     <= 1'b1;
            fill_address_reg <= fetch_address_reg;
          end
        end
        ST_MISS: begin
          if (inp_fillDone) begin
            state_reg      <= ST_FETCH;
            fill_req_reg   <= 1'b0;
            pend_valid_reg <= 1'b0;
          end else if (any_redirect) begin
            // Newest redirect replaces any older one; branch beats jump.
            pend_valid_reg  <= 1'b1;
            pend_target_reg <= inp_branchTaken ? inp_branchTarget : inp_jumpTarget;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_fetchAddress           = fetch_address_reg;
  assign out_nextInstructionAddress = next_address;
  assign out_pcEnable               = pc_enable;
  assign out_fillReq                = fill_req_reg;
  assign out_fillAddress            = fill_address_reg;
  assign out_instValid              = in_fetch & inp_cacheHit & ~any_redirect;
  assign out_state                  = state_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a directed vector table, a reset-during-miss
// sequence, and a randomized run against a transaction-level reference model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        hit, fd, stall, br, jmp;
  logic [15:0] bt, jt;
  logic [15:0] fa, nx, faddr;
  logic        pce, freq, iv;
  logic [1:0]  st;

  int errors = 0;
  int checks = 0;

  fetch_controller dut (
    .inp_clk                    (clk),
    .inp_rst                    (rst),
    .inp_cacheHit               (hit),
    .inp_fillDone               (fd),
    .inp_stall                  (stall),
    .inp_branchTaken            (br),
    .inp_branchTarget           (bt),
    .inp_jump                   (jmp),
    .inp_jumpTarget             (jt),
    .out_fetchAddress           (fa),
    .out_nextInstructionAddress (nx),
    .out_pcEnable               (pce),
    .out_fillReq                (freq),
    .out_fillAddress            (faddr),
    .out_instValid              (iv),
    .out_state                  (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit, fd, stall, br;
    logic [15:0] bt;
    logic        jmp;
    logic [15:0] jt;
    logic [15:0] e_fa, e_nx;
    logic        e_pce, e_iv, e_freq;
    logic [15:0] e_faddr;
    logic [1:0]  e_st;
  } vec_t;

  vec_t tbl [22];

  // Reference model: state name, fetch address, refill registers and a
  // queue of redirects seen while waiting on a refill (newest at the back).
  int          m_state;  // 0 idle, 1 fetch, 2 miss
  logic [15:0] m_pc, m_faddr;
  logic        m_freq;
  logic [15:0] m_pend_q [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic [15:0] e_fa, input logic [15:0] e_nx, input logic e_pce,
                           input logic e_iv, input logic e_freq, input logic [15:0] e_faddr,
                           input logic [1:0] e_st);
    chk("fetchAddress", fa, e_fa);
    chk("nextAddress", nx, e_nx);
    chk("pcEnable", {15'd0, pce}, {15'd0, e_pce});
    chk("instValid", {15'd0, iv}, {15'd0, e_iv});
    chk("fillReq", {15'd0, freq}, {15'd0, e_freq});
    chk("fillAddress", faddr, e_faddr);
    chk("state", {14'd0, st}, {14'd0, e_st});
  endtask

  task automatic clear_inputs();
    hit = 1'b1; fd = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0; bt = '0; jt = '0;
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 16'h0000; m_faddr = 16'h0000; m_freq = 1'b0;
    m_pend_q.delete();
  endtask

  // Expected combinational outputs from the current model state and inputs.
  task automatic model_comb(output logic [15:0] e_nx, output logic e_pce, output logic e_iv);
    e_nx = m_pc; e_pce = 1'b0; e_iv = 1'b0;
    if (m_state == 1) begin
      if (br)       begin e_nx = bt; e_pce = 1'b1; end
      else if (jmp) begin e_nx = jt; e_pce = 1'b1; end
      else if (hit) begin
        e_iv = 1'b1;
        if (!stall) begin e_nx = m_pc + 16'd1; e_pce = 1'b1; end
      end
    end else if (m_state == 2 && fd) begin
      if (br)                        begin e_nx = bt; e_pce = 1'b1; end
      else if (jmp)                  begin e_nx = jt; e_pce = 1'b1; end
      else if (m_pend_q.size() != 0) begin e_nx = m_pend_q[$]; e_pce = 1'b1; end
    end
  endtask

  task automatic model_step(input logic [15:0] e_nx);
    case (m_state)
      0: m_state = 1;
      1: if (!br && !jmp && !hit) begin m_state = 2; m_freq = 1'b1; m_faddr = m_pc; end
      default: begin
        if (fd) begin
          m_state = 1; m_freq = 1'b0; m_pend_q.delete();
        end else if (br) begin
          m_pend_q.push_back(bt);
        end else if (jmp) begin
          m_pend_q.push_back(jt);
        end
      end
    endcase
    m_pc = e_nx;
  endtask

  initial begin
    logic [15:0] e_nx;
    logic        e_pce, e_iv;

    //             hit fd st br bt       jmp jt       fa       nx       pce iv freq faddr    st
    tbl[0]  = '{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};
    tbl[1]  = '{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001, 1, 1, 0, 16'h0000, 1};
    tbl[2]  = '{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0001, 16'h0002, 1, 1, 0, 16'h0000, 1};
    tbl[3]  = '{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h0003, 1, 1, 0, 16'h0000, 1};
    tbl[4]  = '{1, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0003, 16'hFFFF, 1, 0, 0, 16'h0000, 1};
    tbl[5]  = '{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 0, 16'h0000, 1};
    tbl[6]  = '{1, 0, 0, 1, 16'h0010, 0, 16'h0000, 16'h0000, 16'h0010, 1, 0, 0, 16'h0000, 1};
    tbl[7]  = '{0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 16'h0010, 0, 0, 0, 16'h0000, 1};
    tbl[8]  = '{0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 16'h0010, 0, 0, 1, 16'h0010, 2};
    tbl[9]  = '{0, 0, 0, 1, 16'h0100, 1, 16'h0333, 16'h0010, 16'h0010, 0, 0, 1, 16'h0010, 2};
    tbl[10] = '{0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0010, 16'h0010, 0, 0, 1, 16'h0010, 2};
    tbl[11] = '{0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 16'h0100, 1, 0, 1, 16'h0010, 2};
    tbl[12] = '{1, 0, 1, 1, 16'h0200, 1, 16'h0300, 16'h0100, 16'h0200, 1, 0, 0, 16'h0010, 1};
    tbl[13] = '{1, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0200, 16'h0200, 0, 1, 0, 16'h0010, 1};
    tbl[14] = '{1, 0, 0, 0, 16'h0000, 1, 16'h0050, 16'h0200, 16'h0050, 1, 0, 0, 16'h0010, 1};
    tbl[15] = '{0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0050, 16'h0050, 0, 0, 0, 16'h0010, 1};
    tbl[16] = '{0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0050, 16'h0050, 0, 0, 1, 16'h0050, 2};
    tbl[17] = '{1, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0050, 16'h0050, 0, 0, 1, 16'h0050, 2};
    tbl[18] = '{0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0050, 16'h0050, 0, 0, 1, 16'h0050, 2};
    tbl[19] = '{0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0050, 16'h0050, 0, 0, 1, 16'h0050, 2};
    tbl[20] = '{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0050, 16'h0051, 1, 1, 0, 16'h0050, 1};
    tbl[21] = '{1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0051, 16'h0052, 1, 1, 0, 16'h0050, 1};

    // Reset and directed vectors.
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      hit = tbl[i].hit; fd = tbl[i].fd; stall = tbl[i].stall;
      br = tbl[i].br; bt = tbl[i].bt; jmp = tbl[i].jmp; jt = tbl[i].jt;
      #3;
      $display("vec %0d: fa=%04h nx=%04h pce=%0b iv=%0b freq=%0b faddr=%04h st=%0d",
               i, fa, nx, pce, iv, freq, faddr, st);
      check_all(tbl[i].e_fa, tbl[i].e_nx, tbl[i].e_pce, tbl[i].e_iv,
                tbl[i].e_freq, tbl[i].e_faddr, tbl[i].e_st);
      @(posedge clk); #1;
    end

    // Reset in the middle of a refill with a buffered branch.
    clear_inputs(); hit = 1'b0;
    @(posedge clk); #1;
    br = 1'b1; bt = 16'h0777;
    @(posedge clk); #1;
    clear_inputs(); hit = 1'b0;
    #2 rst = 1'b1;
    #1;
    $display("rst-mid-miss: freq=%0b st=%0d fa=%04h", freq, st, fa);
    chk("rst_fillReq", {15'd0, freq}, 16'd0);
    chk("rst_state", {14'd0, st}, 16'd0);
    chk("rst_fetchAddress", fa, 16'h0000);
    chk("rst_pcEnable", {15'd0, pce}, 16'd0);
    chk("rst_nextAddress", nx, 16'h0000);
    @(posedge clk); #1 rst = 1'b0; hit = 1'b1;
    #3 chk("post_rst_state", {14'd0, st}, 16'd0);
    @(posedge clk); #1;
    #3;
    $display("post-rst fetch: fa=%04h nx=%04h iv=%0b", fa, nx, iv);
    check_all(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd1);
    @(posedge clk); #1 hit = 1'b0;
    @(posedge clk); #1 fd = 1'b1;
    #3;
    $display("post-rst fill: fa=%04h nx=%04h pce=%0b", fa, nx, pce);
    check_all(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 2'd2);
    @(posedge clk); #1 clear_inputs();
    #3 check_all(16'h0001, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0001, 2'd1);

    // Randomized run against the reference model.
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      hit   = ($urandom_range(0, 3) != 0);
      fd    = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 4) == 0);
      br    = ($urandom_range(0, 7) == 0);
      jmp   = ($urandom_range(0, 7) == 0);
      bt    = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      jt    = 16'($urandom);
      #3;
      model_comb(e_nx, e_pce, e_iv);
      $display("rnd %0d: st=%0d fa=%04h nx=%04h pce=%0b iv=%0b freq=%0b", c, st, fa, nx, pce, iv, freq);
      check_all(m_pc, e_nx, e_pce, e_iv, m_freq, m_faddr, 2'(m_state));
      @(posedge clk);
      model_step(e_nx);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
